// File: rtl/aes_datapath.sv
// aes_datapath: r0-r3/key register file, ULA and bus A/B/R network,
// plus the start/done handshake with the AES core.
// Ports:
//   ACLK/ARSTn          clock, async active-low reset
//   control_word        {selA,selB,selR,dest,start,decrypt,FS}
//   wr_control          write bus R into dest; valid_AES back to controller
//   enable_amba/host_*  host load (sel 0-3 r, 4 key) and combinational read
//   aes_*               core start/mode/data/key out, done/result in
module aes_datapath #(
  parameter int DW = 128
) (
  input  logic          ACLK,
  input  logic          ARSTn,
  input  logic [10:0]   control_word,
  input  logic          wr_control,
  output logic          valid_AES,
  input  logic          enable_amba,
  input  logic          host_wr_en,
  input  logic [2:0]    host_wr_sel,
  input  logic [DW-1:0] host_wr_data,
  input  logic [2:0]    host_rd_sel,
  output logic [DW-1:0] host_rd_data,
  output logic          aes_start,
  output logic          aes_decrypt,
  output logic [DW-1:0] aes_din,
  output logic [DW-1:0] aes_key,
  input  logic          aes_done,
  input  logic [DW-1:0] aes_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } st_e;

  logic [1:0] sel_a, sel_b, dest, fs;
  logic       sel_r, start, dec;

  assign sel_a = control_word[10:9];
  assign sel_b = control_word[8:7];
  assign sel_r = control_word[6];
  assign dest  = control_word[5:4];
  assign start = control_word[3];
  assign dec   = control_word[2];
  assign fs    = control_word[1:0];

  logic [DW-1:0] r_q [4];
  logic [DW-1:0] r_d [4];
  logic [DW-1:0] key_q, key_d;
  logic [DW-1:0] res_q, res_d;
  logic [DW-1:0] din_q, din_d;
  logic          start_q, start_d;
  logic          dec_q, dec_d;
  logic          valid_q, valid_d;
  st_e           st_q, st_d;

  logic [DW-1:0] bus_a, bus_b, ula, bus_r;
  logic          host_ok;

  assign bus_a = r_q[sel_a];
  assign bus_b = r_q[sel_b];

  always_comb begin
    ula = bus_a;
    case (fs)
      2'b00:   ula = bus_a ^ bus_b;
      2'b01:   ula = bus_a + {{(DW-1){1'b0}}, 1'b1};
      default: ula = bus_a;
    endcase
  end

  assign bus_r   = sel_r ? res_q : ula;
  assign host_ok = host_wr_en && enable_amba;

  // dest cannot address the key, so a host key write is never blocked
  always_comb begin
    for (int i = 0; i < 4; i++) r_d[i] = r_q[i];
    key_d = key_q;
    if (wr_control)
      r_d[dest] = bus_r;
    else if (host_ok && !host_wr_sel[2])
      r_d[host_wr_sel[1:0]] = host_wr_data;
    if (host_ok && host_wr_sel == 3'd4)
      key_d = host_wr_data;
  end

  always_comb begin
    st_d    = st_q;
    start_d = 1'b0;
    din_d   = din_q;
    dec_d   = dec_q;
    res_d   = res_q;
    valid_d = valid_q;
    case (st_q)
      IDLE: begin
        if (start) begin
          start_d = 1'b1;
          din_d   = bus_b;
          dec_d   = dec;
          st_d    = BUSY;
        end
      end
      BUSY: begin
        if (aes_done) begin
          res_d = aes_dout;
          // a withdrawn request finishes silently
          if (start) begin
            st_d    = DONE;
            valid_d = 1'b1;
          end else begin
            st_d = IDLE;
          end
        end
      end
      DONE: begin
        if (!start) begin
          valid_d = 1'b0;
          st_d    = IDLE;
        end
      end
      default: begin
        st_d    = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      key_q   <= '0;
      res_q   <= '0;
      din_q   <= '0;
      start_q <= 1'b0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
      st_q    <= IDLE;
    end else begin
      for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
      key_q   <= key_d;
      res_q   <= res_d;
      din_q   <= din_d;
      start_q <= start_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    host_rd_data = '0;
    if (!host_rd_sel[2])
      host_rd_data = r_q[host_rd_sel[1:0]];
    else if (host_rd_sel == 3'd4)
      host_rd_data = key_q;
  end

  assign valid_AES   = valid_q;
  assign aes_start   = start_q;
  assign aes_decrypt = dec_q;
  assign aes_din     = din_q;
  assign aes_key     = key_q;

endmodule

// File: tb/tb_aes_datapath.sv
// tb_aes_datapath: vector table for the ULA, hand sequences for the
// AES handshake/abort/reset, and a random run against a register model.
module tb_aes_datapath;

  localparam int DW = 128;

  logic          ACLK = 1'b0;
  logic          ARSTn;
  logic [10:0]   control_word;
  logic          wr_control;
  logic          valid_AES;
  logic          enable_amba;
  logic          host_wr_en;
  logic [2:0]    host_wr_sel;
  logic [DW-1:0] host_wr_data;
  logic [2:0]    host_rd_sel;
  logic [DW-1:0] host_rd_data;
  logic          aes_start;
  logic          aes_decrypt;
  logic [DW-1:0] aes_din;
  logic [DW-1:0] aes_key;
  logic          aes_done;
  logic [DW-1:0] aes_dout;

  int checks = 0;
  int errors = 0;

  aes_datapath #(.DW(DW)) dut (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .control_word(control_word), .wr_control(wr_control),
    .valid_AES(valid_AES), .enable_amba(enable_amba),
    .host_wr_en(host_wr_en), .host_wr_sel(host_wr_sel),
    .host_wr_data(host_wr_data), .host_rd_sel(host_rd_sel),
    .host_rd_data(host_rd_data), .aes_start(aes_start),
    .aes_decrypt(aes_decrypt), .aes_din(aes_din),
    .aes_key(aes_key), .aes_done(aes_done), .aes_dout(aes_dout)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    string         nm;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    fs;
    logic [DW-1:0] exp;
  } vec_t;

  function automatic logic [10:0] mkcw(input int a, b, r, d, st, dc, f);
    logic [10:0] w;
    w = {a[1:0], b[1:0], r[0], d[1:0], st[0], dc[0], f[1:0]};
    return w;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic host_write(input logic [2:0] s, input logic [DW-1:0] d);
    host_wr_sel  = s;
    host_wr_data = d;
    host_wr_en   = 1'b1;
    enable_amba  = 1'b1;
    step();
    host_wr_en = 1'b0;
  endtask

  task automatic ctrl(input logic [10:0] cw);
    control_word = cw;
    wr_control   = 1'b1;
    step();
    wr_control   = 1'b0;
    control_word = '0;
  endtask

  task automatic rd(input string nm, input logic [2:0] s,
                    input logic [DW-1:0] exp);
    host_rd_sel = s;
    #1;
    chk(nm, host_rd_data, exp);
  endtask

  vec_t vecs [6];
  logic [DW-1:0] m_r [4];
  logic [DW-1:0] m_key, m_res;
  logic [DW-1:0] A, D, E, ones;

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    ones = '1;
    A = 128'h00112233_44556677_8899aabb_ccddeeff;
    D = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    E = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    vecs[0] = '{"xor", A, ones, 2'b00, ~A};
    vecs[1] = '{"xor0", A, A, 2'b00, 128'h0};
    vecs[2] = '{"inc_wrap", ones, A, 2'b01, 128'h0};
    vecs[3] = '{"inc5", 128'd5, A, 2'b01, 128'd6};
    vecs[4] = '{"pass", E, A, 2'b10, E};
    vecs[5] = '{"rsvd", D, A, 2'b11, D};

    ARSTn = 1'b0;
    control_word = '0;
    wr_control = 1'b0;
    enable_amba = 1'b0;
    host_wr_en = 1'b0;
    host_wr_sel = '0;
    host_wr_data = '0;
    host_rd_sel = '0;
    aes_done = 1'b0;
    aes_dout = '0;
    #12;
    for (int i = 0; i < 5; i++) rd("rst_reg", 3'(i), '0);
    chk("rst_valid", 128'(valid_AES), 0);
    chk("rst_start", 128'(aes_start), 0);
    chk("rst_dec", 128'(aes_decrypt), 0);
    chk("rst_din", aes_din, '0);
    chk("rst_key", aes_key, '0);
    @(negedge ACLK);
    ARSTn = 1'b1;
    step();

    // ULA vectors: r0=a, r1=b, op into r2
    for (int i = 0; i < 6; i++) begin
      host_write(3'd0, vecs[i].a);
      host_write(3'd1, vecs[i].b);
      ctrl(mkcw(0, 1, 0, 2, 0, 0, int'(vecs[i].fs)));
      rd(vecs[i].nm, 3'd2, vecs[i].exp);
    end

    // INC in place on r3
    host_write(3'd3, ones);
    ctrl(mkcw(3, 0, 0, 3, 0, 0, 1));
    rd("r3_wrap", 3'd3, '0);
    host_write(3'd3, 128'd5);
    ctrl(mkcw(3, 0, 0, 3, 0, 0, 1));
    rd("r3_inc", 3'd3, 128'd6);

    // key and out-of-range selects
    host_write(3'd4, E);
    chk("key_out", aes_key, E);
    rd("key_rd", 3'd4, E);
    host_write(3'd5, A);
    rd("sel5", 3'd5, '0);
    rd("sel7", 3'd7, '0);

    // AES encrypt, done at cycle 10
    host_write(3'd0, A);
    host_write(3'd1, E);
    control_word = mkcw(0, 0, 0, 0, 1, 0, 0);
    @(negedge ACLK);
    chk("c0_start", 128'(aes_start), 0);
    step();
    control_word = mkcw(1, 1, 0, 0, 1, 1, 0);
    @(negedge ACLK);
    chk("c1_start", 128'(aes_start), 1);
    chk("c1_din", aes_din, A);
    chk("c1_dec", 128'(aes_decrypt), 0);
    for (int c = 2; c <= 10; c++) begin
      step();
      if (c == 10) begin
        aes_done = 1'b1;
        aes_dout = D;
      end
      @(negedge ACLK);
      chk("busy_start", 128'(aes_start), 0);
      chk("busy_valid", 128'(valid_AES), 0);
    end
    chk("busy_din", aes_din, A);
    step();
    aes_done = 1'b0;
    aes_dout = E;
    @(negedge ACLK);
    chk("c11_valid", 128'(valid_AES), 1);
    step();
    @(negedge ACLK);
    chk("hold_valid", 128'(valid_AES), 1);
    step();
    control_word = mkcw(0, 0, 1, 2, 0, 0, 0);
    wr_control = 1'b1;
    @(negedge ACLK);
    chk("wb_valid", 128'(valid_AES), 1);
    step();
    wr_control = 1'b0;
    control_word = '0;
    @(negedge ACLK);
    chk("wb_clr", 128'(valid_AES), 0);
    rd("wb_r2", 3'd2, D);

    // priority: control beats host on r1; host ignored without enable
    host_write(3'd0, A);
    host_wr_sel = 3'd1;
    host_wr_data = E;
    host_wr_en = 1'b1;
    ctrl(mkcw(0, 0, 0, 1, 0, 0, 2));
    host_wr_en = 1'b0;
    rd("prio_r1", 3'd1, A);
    host_wr_sel = 3'd1;
    host_wr_data = E;
    host_wr_en = 1'b1;
    enable_amba = 1'b0;
    step();
    host_wr_en = 1'b0;
    rd("noen_r1", 3'd1, A);

    // random register traffic against a model
    m_res = D;
    for (int i = 0; i < 4; i++) begin
      m_r[i] = rnd();
      host_write(3'(i), m_r[i]);
    end
    m_key = rnd();
    host_write(3'd4, m_key);
    for (int n = 0; n < 300; n++) begin
      logic [10:0] cw;
      logic [DW-1:0] ba, ula, br, dat, expv;
      logic w, he, en;
      logic [2:0] ws, rs;
      cw = 11'($urandom);
      cw[3] = 1'b0;
      if (cw[1:0] == 2'b01 && $urandom % 3 == 0) m_r[cw[10:9]] = m_r[cw[10:9]];
      w = 1'($urandom);
      he = 1'($urandom);
      en = 1'($urandom);
      ws = 3'($urandom);
      rs = 3'($urandom);
      dat = ($urandom % 8 == 0) ? ones : rnd();
      if (w && ws == 3'd4) he = 1'b0;
      control_word = cw;
      wr_control = w;
      host_wr_en = he;
      enable_amba = en;
      host_wr_sel = ws;
      host_wr_data = dat;
      host_rd_sel = rs;
      @(negedge ACLK);
      expv = (rs < 4) ? m_r[rs[1:0]] : (rs == 4) ? m_key : '0;
      chk("rand_rd", host_rd_data, expv);
      chk("rand_key", aes_key, m_key);
      ba = m_r[cw[10:9]];
      case (cw[1:0])
        2'b00: ula = ba ^ m_r[cw[8:7]];
        2'b01: ula = ba + 1;
        default: ula = ba;
      endcase
      br = cw[6] ? m_res : ula;
      if (w) m_r[cw[5:4]] = br;
      else if (he && en && ws < 4) m_r[ws[1:0]] = dat;
      if (he && en && ws == 4) m_key = dat;
      step();
    end
    wr_control = 1'b0;
    host_wr_en = 1'b0;
    control_word = '0;

    // abort: start withdrawn during BUSY, decrypt mode
    host_write(3'd0, A);
    control_word = mkcw(0, 0, 0, 0, 1, 1, 0);
    step();
    @(negedge ACLK);
    chk("ab_dec", 128'(aes_decrypt), 1);
    chk("ab_start", 128'(aes_start), 1);
    step();
    control_word = '0;
    step();
    aes_done = 1'b1;
    aes_dout = E;
    step();
    aes_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      chk("ab_valid", 128'(valid_AES), 0);
      step();
    end
    ctrl(mkcw(0, 0, 1, 3, 0, 0, 0));
    rd("ab_res", 3'd3, E);
    control_word = mkcw(0, 0, 0, 0, 1, 0, 0);
    step();
    @(negedge ACLK);
    chk("restart", 128'(aes_start), 1);

    // async reset mid-BUSY
    step();
    #2;
    ARSTn = 1'b0;
    #1;
    chk("ar_valid", 128'(valid_AES), 0);
    chk("ar_start", 128'(aes_start), 0);
    chk("ar_din", aes_din, '0);
    chk("ar_key", aes_key, '0);
    rd("ar_r0", 3'd0, '0);
    control_word = '0;
    @(negedge ACLK);
    ARSTn = 1'b1;
    step();
    aes_done = 1'b1;
    aes_dout = D;
    step();
    aes_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      chk("stray_valid", 128'(valid_AES), 0);
      chk("stray_start", 128'(aes_start), 0);
      step();
    end
    ctrl(mkcw(0, 0, 1, 1, 0, 0, 0));
    rd("stray_res", 3'd1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_datapath.md
# aes_datapath

Register-file and ULA datapath for the AES peripheral, sitting directly downstream of the instruction-sequencing controller. It holds working registers r0–r3 plus a key register, decodes the 11-bit control word, and evaluates the bus A / bus B / bus R network. It writes results back on the controller's write strobe and runs the start/done handshake with the AES core, returning `valid_AES` to the controller. The AMBA slave loads and reads the registers through a host port while the controller grants bus use.

## Interface
Parameters:
- `DW`, 128, datapath and register width.

Ports:
- `ACLK`  in  1  clock; all state updates on the rising edge.
- `ARSTn`  in  1  reset, asynchronous, active-low.
- `control_word`  in  11  `{SEL_busA[10:9], SEL_busB[8:7], SEL_busR[6], reg_DEST[5:4], start_AES[3], decrypt[2], FS[1:0]}`.
- `wr_control`  in  1  write strobe: bus R is written to `reg_DEST`.
- `valid_AES`  out  1  AES result captured; held until `start_AES` falls.
- `enable_amba`  in  1  host port enable; 1 = host owns the registers.
- `host_wr_en`  in  1  host write strobe.
- `host_wr_sel`  in  3  0–3 = r0–r3, 4 = key, 5–7 = ignored.
- `host_wr_data`  in  DW  host write data.
- `host_rd_sel`  in  3  read select, same encoding; 5–7 read 0.
- `host_rd_data`  out  DW  combinational mux of the selected register.
- `aes_start`  out  1  one-cycle start pulse to the AES core.
- `aes_decrypt`  out  1  mode captured at start (1 = decrypt).
- `aes_din`  out  DW  core input, captured from bus B at start.
- `aes_key`  out  DW  the key register, driven continuously.
- `aes_done`  in  1  core completion pulse.
- `aes_dout`  in  DW  core output, valid in the `aes_done` cycle.

## Operation
- Bus A = register selected by `SEL_busA`; bus B = register selected by `SEL_busB`. Both are combinational.
- ULA function select `FS`:
  - 00: `busA ^ busB`.
  - 01: `busA + 1`, modulo 2^DW (all-ones wraps to 0).
  - 10: `busA`.
  - 11: reserved, behaves as 10.
- Bus R: `SEL_busR` = 0 selects the ULA output; 1 selects the `aes_result` register.
- Register write priority per edge:
  - `wr_control` = 1: `reg_DEST` <= bus R.
  - Otherwise, `host_wr_en && enable_amba`: selected register <= `host_wr_data`.
  - Host writes while `enable_amba` = 0 are dropped.
  - Host writes to the key register never collide with `wr_control`, since `reg_DEST` cannot address the key.
- AES handshake FSM, states IDLE, BUSY, DONE:
  - IDLE: if `start_AES` = 1, register `aes_start` = 1, `aes_din` = bus B and `aes_decrypt` = `decrypt`, then go to BUSY.
  - BUSY: `aes_start` returns to 0. When `aes_done` = 1, `aes_result` <= `aes_dout`.
    - If `start_AES` is still 1, go to DONE.
    - Otherwise (request withdrawn), go to IDLE with no `valid_AES`.
  - DONE: `valid_AES` = 1. When `start_AES` = 0, clear `valid_AES` and go to IDLE.
- `aes_done` while in IDLE or DONE is ignored.
- `aes_result` keeps its value until the next capture, so a later `SEL_busR` = 1 write reuses the last result.

## Timing
- Reset values: r0–r3, key, `aes_result`, `aes_din` = 0; `aes_start`, `aes_decrypt`, `valid_AES` = 0; FSM = IDLE.
- Reset asserted mid-operation aborts the handshake immediately; a late `aes_done` after reset release is ignored.
- Register write: takes effect on the edge where `wr_control` = 1 and is visible on bus A/B and `host_rd_data` in the next cycle.
- AES sequence, with cycle 0 = first cycle `start_AES` = 1 is sampled:
  - `aes_start` is high in cycle 1 only.
  - `aes_done` in cycle k (k ≥ 2) gives `valid_AES` = 1 from cycle k+1.
- Controller writeback: `start_AES` drops and `wr_control` rises in the same cycle. `aes_result` is already stable, so the write lands correctly. `valid_AES` falls one cycle after `start_AES` falls.
- `start_AES` re-rising in the cycle after DONE→IDLE starts a new operation; no bubble is required beyond the IDLE cycle.

## Test plan
- Host loads r0 = 0x00112233…, r1 = 0xFFFF…FF with `enable_amba` = 1. Apply control word XOR r1,r0→r2 and pulse `wr_control` → r2 = r0 ^ r1 next cycle; `host_rd_sel` = 2 reads it back.
- INC wrap: r3 = all-ones, `FS` = 01, `SEL_busA` = r3, `reg_DEST` = r3, `wr_control` → r3 = 0. Repeat with r3 = 5 → r3 = 6.
- AES encrypt: r0 = A, raise `start_AES` with `SEL_busB` = r0, `decrypt` = 0.
  - `aes_start` pulses once with `aes_din` = A and `aes_decrypt` = 0.
  - Model returns `aes_done` after 10 cycles with D → `valid_AES` the next cycle.
  - Controller drops start and writes r2 → r2 = D, and `valid_AES` clears.
- Priority: `wr_control` and host write target r1 in the same cycle → control value wins. Host write with `enable_amba` = 0 → r1 unchanged.
- Abort:
  - Drop `start_AES` during BUSY, then `aes_done` → `valid_AES` stays 0 and FSM returns to IDLE.
  - Assert `ARSTn` = 0 mid-BUSY → all outputs return to reset values asynchronously, and a subsequent stray `aes_done` is ignored.
